// File: rtl/pgt_source_sel.sv
// pgt_source_sel: selects the pulse source feeding the timer.
// The count input (cont) and the magnetron enable (sel) are synchronised.
// A 1 Hz style tick is derived from clk by a modulo-DIV divider.
// pgt carries one-cycle pulses from either source.
// Source changes pass through a blanking interval of GUARD cycles, so a
// switch can never emit a spurious or truncated pulse.
module pgt_source_sel #(
  parameter int DIV         = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD       = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             cont,
  output logic             pgt,
  output logic             src_div,
  output logic             switching,
  output logic [CNT_W-1:0] pgt_count
);

  localparam int DIV_W = $clog2(DIV);
  localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD - 1);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_TO_DIV  = 2'd1,
    S_DIV     = 2'd2,
    S_TO_LOAD = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] cont_sync_r;
  logic [SYNC_STAGES-1:0] sel_sync_r;
  logic                   cont_prev_r;
  logic                   cont_s;
  logic                   sel_s;
  logic                   cont_edge_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [GRD_W-1:0]       guard_r;
  logic [GRD_W-1:0]       guard_nxt_s;
  logic [DIV_W-1:0]       div_r;
  logic [DIV_W-1:0]       div_nxt_s;
  logic                   pgt_r;
  logic                   pgt_nxt_s;
  logic                   src_div_r;
  logic                   switching_r;
  logic [CNT_W-1:0]       count_r;

  assign cont_s      = cont_sync_r[SYNC_STAGES-1];
  assign sel_s       = sel_sync_r[SYNC_STAGES-1];
  // The edge history runs in every state. A cont level held across a
  // source switch therefore never looks like a new edge.
  assign cont_edge_s = cont_s & ~cont_prev_r;

  // Input synchroniser chains and the cont edge-history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_sync_r <= '0;
      sel_sync_r  <= '0;
      cont_prev_r <= 1'b0;
    end else begin
      cont_sync_r <= {cont_sync_r[SYNC_STAGES-2:0], cont};
      sel_sync_r  <= {sel_sync_r[SYNC_STAGES-2:0], sel};
      cont_prev_r <= cont_s;
    end
  end

  // Next-state logic: source selection, guard countdown, divider and pulse request.
  always_comb begin
    state_nxt_s = state_r;
    guard_nxt_s = guard_r;
    div_nxt_s   = div_r;
    pgt_nxt_s   = 1'b0;
    case (state_r)
      S_LOAD: begin
        // The edge is served before any transition, so a coincident sel rise still pulses.
        pgt_nxt_s = cont_edge_s;
        if (sel_s) begin
          state_nxt_s = S_TO_DIV;
          guard_nxt_s = GRD_LOAD;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_TO_DIV: begin
        if (!sel_s) begin
          state_nxt_s = S_LOAD;
        end else if (guard_r == {GRD_W{1'b0}}) begin
          state_nxt_s = S_DIV;
          div_nxt_s   = {DIV_W{1'b0}};
        end else begin
          guard_nxt_s = guard_r - GRD_W'(1);
        end
      end
      S_DIV: begin
        if (!sel_s) begin
          // Leaving the divider wins over a wrap on the same edge, so no tick is issued.
          state_nxt_s = S_TO_LOAD;
          guard_nxt_s = GRD_LOAD;
        end else if (div_r == DIV_LAST) begin
          div_nxt_s = {DIV_W{1'b0}};
          pgt_nxt_s = 1'b1;
        end else begin
          div_nxt_s = div_r + DIV_W'(1);
        end
      end
      S_TO_LOAD: begin
        if (sel_s) begin
          state_nxt_s = S_DIV;
          div_nxt_s   = {DIV_W{1'b0}};
        end else if (guard_r == {GRD_W{1'b0}}) begin
          state_nxt_s = S_LOAD;
        end else begin
          guard_nxt_s = guard_r - GRD_W'(1);
        end
      end
      default: begin
        state_nxt_s = S_LOAD;
        guard_nxt_s = {GRD_W{1'b0}};
        div_nxt_s   = {DIV_W{1'b0}};
        pgt_nxt_s   = 1'b0;
      end
    endcase
  end

  // State register together with the registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_LOAD;
      guard_r     <= {GRD_W{1'b0}};
      div_r       <= {DIV_W{1'b0}};
      pgt_r       <= 1'b0;
      src_div_r   <= 1'b0;
      switching_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      guard_r     <= guard_nxt_s;
      div_r       <= div_nxt_s;
      pgt_r       <= pgt_nxt_s;
      src_div_r   <= (state_nxt_s == S_DIV);
      switching_r <= (state_nxt_s == S_TO_DIV) || (state_nxt_s == S_TO_LOAD);
    end
  end

  // Debug counter of issued pulses. It wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (pgt_r) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign pgt       = pgt_r;
  assign src_div   = src_div_r;
  assign switching = switching_r;
  assign pgt_count = count_r;

endmodule

// File: tb/tb_pgt_source_sel.sv
// Testbench for pgt_source_sel.
// Stimulus pushes the cycle at which each pgt pulse is expected.
// A monitor on the falling edge pops and matches every pulse the DUT emits.
module tb_pgt_source_sel;

  localparam int DIV   = 10;
  localparam int SYNC  = 2;
  localparam int GUARD = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             sel;
  logic             cont;
  logic             pgt;
  logic             src_div;
  logic             switching;
  logic [CNT_W-1:0] pgt_count;

  int errors;
  int checks;
  int cyc;
  int exp_q[$];
  logic pgt_prev;

  pgt_source_sel #(
    .DIV(DIV),
    .SYNC_STAGES(SYNC),
    .GUARD(GUARD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sel(sel),
    .cont(cont),
    .pgt(pgt),
    .src_div(src_div),
    .switching(switching),
    .pgt_count(pgt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the queue head, and overdue entries are reported.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: got none, expected pgt at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (pgt) begin
        checks++;
        if (pgt_prev) begin
          errors++;
          $display("FAIL pulse_width: pgt high on consecutive cycles at %0d", cyc);
        end else if (exp_q.size() == 0 || exp_q[0] != cyc) begin
          errors++;
          $display("FAIL unexpected_pulse: got pgt at cycle %0d, expected %0d", cyc,
                   (exp_q.size() == 0) ? -1 : exp_q[0]);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      pgt_prev <= pgt;
    end else begin
      pgt_prev <= 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cont pulse; the pgt pulse is expected SYNC+1 edges after the drive point.
  task automatic pulse_cont(input bit expect_pgt, input int hi, input int lo);
    if (expect_pgt) exp_q.push_back(cyc + 1 + SYNC);
    cont = 1'b1;
    step(hi);
    cont = 1'b0;
    step(lo);
  endtask

  int n0;

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    pgt_prev = 1'b0;
    rst_n    = 1'b0;
    sel      = 1'b0;
    cont     = 1'b0;

    // Reset held: inputs toggling, outputs must stay cleared.
    for (int i = 0; i < 8; i++) begin
      step(1);
      cont = i[0];
      sel  = i[1];
      chk("rst_pgt", int'(pgt), 0);
      chk("rst_count", int'(pgt_count), 0);
      chk("rst_src_div", int'(src_div), 0);
      chk("rst_switching", int'(switching), 0);
    end
    cont = 1'b0;
    sel  = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Load path: three cont pulses of 5 cycles.
    for (int i = 0; i < 3; i++) pulse_cont(1'b1, 5, 3);
    step(3);
    chk("load_count", int'(pgt_count), 3);
    chk("load_src_div", int'(src_div), 0);
    chk("load_switching", int'(switching), 0);

    // Divider path, with a cont edge coincident with the sel rise.
    n0 = cyc;
    exp_q.push_back(n0 + 3);
    cont = 1'b1;
    sel  = 1'b1;
    step(3);
    chk("to_div_switching_1", int'(switching), 1);
    chk("to_div_src_div", int'(src_div), 0);
    step(1);
    chk("to_div_switching_2", int'(switching), 1);
    step(1);
    cont = 1'b0;
    chk("div_switching", int'(switching), 0);
    chk("div_src_div", int'(src_div), 1);
    exp_q.push_back(n0 + 15);
    exp_q.push_back(n0 + 25);
    exp_q.push_back(n0 + 35);
    wait_to(n0 + 8);  cont = 1'b1;
    wait_to(n0 + 11); cont = 1'b0;
    wait_to(n0 + 18); cont = 1'b1;
    wait_to(n0 + 21); cont = 1'b0;
    wait_to(n0 + 28); cont = 1'b1;
    // sel_s falls on the cycle the divider sits at DIV-1, so the tick is suppressed.
    wait_to(n0 + 42); sel = 1'b0;
    wait_to(n0 + 45);
    chk("blank_switching", int'(switching), 1);
    chk("blank_src_div", int'(src_div), 0);
    wait_to(n0 + 48);
    chk("back_load_switching", int'(switching), 0);
    chk("back_load_src_div", int'(src_div), 0);
    wait_to(n0 + 55);
    chk("div_count", int'(pgt_count), 7);
    cont = 1'b0;
    step(3);
    pulse_cont(1'b1, 2, 3);
    chk("fresh_edge_count", int'(pgt_count), 8);

    // Aborted switch: sel drops during the guard interval.
    n0  = cyc;
    sel = 1'b1;
    step(2);
    sel = 1'b0;
    step(1);
    chk("abort_switching", int'(switching), 1);
    for (int i = 0; i < 8; i++) begin
      chk("abort_src_div", int'(src_div), 0);
      step(1);
    end
    chk("abort_end_switching", int'(switching), 0);
    chk("abort_count", int'(pgt_count), 8);

    // Asynchronous reset mid-operation while in the divider state.
    n0  = cyc;
    sel = 1'b1;
    exp_q.push_back(n0 + 15);
    wait_to(n0 + 17);
    chk("pre_reset_src_div", int'(src_div), 1);
    chk("pre_reset_count", int'(pgt_count), 9);
    #1;
    rst_n = 1'b0;
    sel   = 1'b0;
    exp_q.delete();
    #1;
    chk("async_pgt", int'(pgt), 0);
    chk("async_count", int'(pgt_count), 0);
    chk("async_src_div", int'(src_div), 0);
    chk("async_switching", int'(switching), 0);
    #3;
    rst_n = 1'b1;
    step(6);
    chk("post_reset_count", int'(pgt_count), 0);

    // 300-pulse run: the counter wraps 255 -> 0 and finally reads 300 mod 256 = 44.
    for (int i = 0; i < 300; i++) begin
      pulse_cont(1'b1, 2, 2);
      if (i == 254) chk("count_255", int'(pgt_count), 255);
      if (i == 255) chk("count_wrap", int'(pgt_count), 0);
    end
    step(2);
    chk("final_count", int'(pgt_count), 44);

    step(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
